// File: rtl/lif_layer_sequencer.sv
// Time-multiplexes one timestep of currents across N LIF neurons, pulsing each enable in
// index order, gathering the spikes into a vector and returning it over a handshake.
module lif_layer_sequencer #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step_valid_i,
  output logic           step_ready_o,
  input  logic [N*W-1:0] step_current_i,
  output logic [N*W-1:0] neuron_current_o,
  output logic [N-1:0]   neuron_enable_o,
  output logic [4:0]     threshold_o,
  output logic [2:0]     decay_o,
  output logic [4:0]     refractory_period_o,
  input  logic [N-1:0]   spike_in_i,
  output logic           spike_valid_o,
  input  logic           spike_ready_i,
  output logic [N-1:0]   spike_vec_o,
  output logic [15:0]    step_count_o,
  input  logic           cfg_we_i,
  input  logic [1:0]     cfg_addr_i,
  input  logic [4:0]     cfg_wdata_i,
  output logic           cfg_err_o
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StUpdate, StDrain, StOutput} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [N-1:0]      en_q;
  logic [N-1:0]      en_prev_q;
  logic [N-1:0]      spike_vec_q;
  logic              spike_valid_q;
  logic              step_ready_q;
  logic [N*W-1:0]    current_q;
  logic [15:0]       step_count_q;
  logic [4:0]        threshold_q;
  logic [2:0]        decay_q;
  logic [4:0]        refractory_q;
  logic              cfg_err_q;
  logic              cfg_ok;

  assign cfg_ok = cfg_we_i && (state_q == StIdle) && (cfg_addr_i != 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      en_q          <= '0;
      en_prev_q     <= '0;
      spike_vec_q   <= '0;
      spike_valid_q <= 1'b0;
      step_ready_q  <= 1'b1;
      current_q     <= '0;
      step_count_q  <= '0;
      threshold_q   <= 5'd8;
      decay_q       <= 3'd1;
      refractory_q  <= 5'd2;
      cfg_err_q     <= 1'b0;
    end else begin
      // A neuron's spike appears one cycle after its enable, so mask by last cycle's enable.
      en_prev_q <= en_q;
      cfg_err_q <= cfg_we_i & ~cfg_ok;
      if (cfg_ok) begin
        case (cfg_addr_i)
          2'd0:    threshold_q  <= cfg_wdata_i;
          2'd1:    decay_q      <= cfg_wdata_i[2:0];
          2'd2:    refractory_q <= cfg_wdata_i;
          default: ;
        endcase
      end

      unique case (state_q)
        StIdle: begin
          if (step_valid_i) begin
            current_q    <= step_current_i;
            spike_vec_q  <= '0;
            idx_q        <= '0;
            en_q         <= N'(1);
            step_ready_q <= 1'b0;
            state_q      <= StUpdate;
          end
        end
        StUpdate: begin
          spike_vec_q <= spike_vec_q | (spike_in_i & en_prev_q);
          if (idx_q == LastIdx) begin
            en_q    <= '0;
            state_q <= StDrain;
          end else begin
            en_q  <= en_q << 1;
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDrain: begin
          spike_vec_q   <= spike_vec_q | (spike_in_i & en_prev_q);
          spike_valid_q <= 1'b1;
          state_q       <= StOutput;
        end
        StOutput: begin
          if (spike_ready_i) begin
            spike_valid_q <= 1'b0;
            step_ready_q  <= 1'b1;
            step_count_q  <= step_count_q + 16'd1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign step_ready_o        = step_ready_q;
  assign neuron_current_o    = current_q;
  assign neuron_enable_o     = en_q;
  assign threshold_o         = threshold_q;
  assign decay_o             = decay_q;
  assign refractory_period_o = refractory_q;
  assign spike_valid_o       = spike_valid_q;
  assign spike_vec_o         = spike_vec_q;
  assign step_count_o        = step_count_q;
  assign cfg_err_o           = cfg_err_q;

endmodule

// File: tb/tb_lif_layer_sequencer.sv
// Randomized bench: neurons are emulated by a responder that fires a chosen pattern one cycle
// after each enable and sprays stray spikes elsewhere; a small model tracks config and counts.
module tb_lif_layer_sequencer;
  localparam int N = 8;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           step_valid;
  logic           step_ready;
  logic [N*W-1:0] step_current;
  logic [N*W-1:0] neuron_current;
  logic [N-1:0]   neuron_enable;
  logic [4:0]     threshold;
  logic [2:0]     decay;
  logic [4:0]     refractory_period;
  logic [N-1:0]   spike_in;
  logic           spike_valid;
  logic           spike_ready;
  logic [N-1:0]   spike_vec;
  logic [15:0]    step_count;
  logic           cfg_we;
  logic [1:0]     cfg_addr;
  logic [4:0]     cfg_wdata;
  logic           cfg_err;

  lif_layer_sequencer #(.N(N), .W(W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .step_valid_i        (step_valid),
    .step_ready_o        (step_ready),
    .step_current_i      (step_current),
    .neuron_current_o    (neuron_current),
    .neuron_enable_o     (neuron_enable),
    .threshold_o         (threshold),
    .decay_o             (decay),
    .refractory_period_o (refractory_period),
    .spike_in_i          (spike_in),
    .spike_valid_o       (spike_valid),
    .spike_ready_i       (spike_ready),
    .spike_vec_o         (spike_vec),
    .step_count_o        (step_count),
    .cfg_we_i            (cfg_we),
    .cfg_addr_i          (cfg_addr),
    .cfg_wdata_i         (cfg_wdata),
    .cfg_err_o           (cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] pattern = '0;
  logic [N-1:0] en_seen = '0;
  logic [4:0]   thr_m = 5'd8;
  logic [2:0]   dec_m = 3'd1;
  logic [4:0]   ref_m = 5'd2;
  logic [15:0]  count_m = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cfg(input string tag);
    check_eq({tag, "_thr"}, threshold, thr_m);
    check_eq({tag, "_dec"}, decay, dec_m);
    check_eq({tag, "_ref"}, refractory_period, ref_m);
  endtask

  task automatic model_cfg(input logic [1:0] a, input logic [4:0] d);
    case (a)
      2'd0:    thr_m = d;
      2'd1:    dec_m = d[2:0];
      2'd2:    ref_m = d;
      default: ;
    endcase
  endtask

  function automatic logic [N*W-1:0] rand_cur();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[N*W-1:0];
  endfunction

  // Neuron emulation: spike i appears in the cycle after enable i, per the chosen pattern.
  initial begin
    spike_in = '0;
    forever begin
      @(negedge clk);
      en_seen = neuron_enable;
      @(posedge clk);
      #1;
      spike_in = (en_seen & pattern) | (N'($urandom()) & ~en_seen);
    end
  end

  // Starts and ends one time unit after a rising edge, with the DUT idle.
  task automatic cfg_write(input logic [1:0] a, input logic [4:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    model_cfg(a, d);
    @(negedge clk);
    check_eq("cfg_err_idle", cfg_err, a == 2'd3);
    check_cfg("cfg_idle");
    tick();
    @(negedge clk);
    check_eq("cfg_err_drop", cfg_err, 1'b0);
    tick();
  endtask

  task automatic run_step(input logic [N*W-1:0] cur, input logic [N-1:0] pat, input int stall,
                          input bit mid_cfg, input bit with_cfg, input logic [1:0] ca,
                          input logic [4:0] cd);
    logic [N-1:0] exp_en;
    pattern = pat;
    step_current = cur;
    step_valid = 1'b1;
    if (with_cfg) begin
      cfg_we = 1'b1;
      cfg_addr = ca;
      cfg_wdata = cd;
    end
    @(negedge clk);
    check_eq("ready_idle", step_ready, 1'b1);
    tick();
    step_valid = 1'b0;
    cfg_we = 1'b0;
    step_current = rand_cur();
    if (with_cfg) model_cfg(ca, cd);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      exp_en = N'(1) << i;
      check_eq("enable_walk", neuron_enable, exp_en);
      check_eq("ready_busy", step_ready, 1'b0);
      check_eq("valid_busy", spike_valid, 1'b0);
      check_eq("cfg_err_step", cfg_err, (i == 0) ? (with_cfg && ca == 2'd3) : (i == 1 && mid_cfg));
      check_cfg("cfg_step");
      check_eq("cur_latched", neuron_current, cur);
      spike_ready = 1'($urandom());
      if (i == 0 && mid_cfg) begin
        cfg_we = 1'b1;
        cfg_addr = 2'd1;
        cfg_wdata = 5'($urandom());
      end
      tick();
      cfg_we = 1'b0;
    end
    spike_ready = 1'b0;
    @(negedge clk);
    check_eq("drain_en", neuron_enable, '0);
    check_eq("drain_valid", spike_valid, 1'b0);
    tick();
    @(negedge clk);
    check_eq("out_valid", spike_valid, 1'b1);
    check_eq("out_vec", spike_vec, pat);
    check_eq("out_ready", step_ready, 1'b0);
    for (int s = 0; s < stall; s++) begin
      step_valid = 1'b1;
      step_current = rand_cur();
      tick();
      @(negedge clk);
      check_eq("stall_valid", spike_valid, 1'b1);
      check_eq("stall_vec", spike_vec, pat);
      check_eq("stall_ready", step_ready, 1'b0);
      check_eq("stall_cur", neuron_current, cur);
      check_eq("stall_en", neuron_enable, '0);
    end
    step_valid = 1'b0;
    spike_ready = 1'b1;
    tick();
    spike_ready = 1'b0;
    count_m++;
    @(negedge clk);
    check_eq("post_valid", spike_valid, 1'b0);
    check_eq("post_count", step_count, count_m);
    check_eq("post_ready", step_ready, 1'b1);
    check_eq("post_cur", neuron_current, cur);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*W-1:0] cur;
    reset = 1'b1;
    step_valid = 1'b0;
    step_current = '0;
    spike_ready = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_cfg("rst");
    check_eq("rst_ready", step_ready, 1'b1);
    check_eq("rst_en", neuron_enable, '0);
    check_eq("rst_valid", spike_valid, 1'b0);
    check_eq("rst_vec", spike_vec, '0);
    check_eq("rst_cur", neuron_current, '0);
    check_eq("rst_count", step_count, '0);
    check_eq("rst_err", cfg_err, 1'b0);
    tick();

    // Reset while neuron 4 is being enabled aborts the step and restores config defaults.
    cfg_write(2'd0, 5'd20);
    step_valid = 1'b1;
    step_current = rand_cur();
    tick();
    step_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check_eq("mid_en4", neuron_enable, 8'h10);
    reset = 1'b1;
    #1;
    thr_m = 5'd8;
    dec_m = 3'd1;
    ref_m = 5'd2;
    check_eq("mid_rst_en", neuron_enable, '0);
    check_eq("mid_rst_valid", spike_valid, 1'b0);
    check_eq("mid_rst_count", step_count, count_m);
    check_eq("mid_rst_ready", step_ready, 1'b1);
    check_cfg("mid_rst");
    tick();
    reset = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      check_eq("aborted_valid", spike_valid, 1'b0);
      check_eq("aborted_en", neuron_enable, '0);
    end
    tick();

    for (int k = 0; k < N; k++) cur[k*W +: W] = 5'd3;
    run_step(cur, '0, 0, 1'b0, 1'b0, 2'd0, 5'd0);

    cfg_write(2'd0, 5'd4);
    cur = '0;
    cur[0 +: W] = 5'd7;
    cur[(N-1)*W +: W] = 5'd7;
    run_step(cur, 8'h81, 0, 1'b0, 1'b0, 2'd0, 5'd0);

    cfg_write(2'd0, 5'd10);
    cfg_write(2'd3, 5'd17);
    run_step(rand_cur(), 8'h24, 0, 1'b1, 1'b0, 2'd0, 5'd0);
    check_eq("cfg_thr10", threshold, 5'd10);
    check_eq("cfg_dec_kept", decay, 3'd1);

    run_step(rand_cur(), 8'h5a, 20, 1'b0, 1'b0, 2'd0, 5'd0);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) cfg_write(2'($urandom()), 5'($urandom()));
      run_step(rand_cur(), N'($urandom()), $urandom_range(0, 3), 1'($urandom()),
               1'($urandom()), 2'($urandom()), 5'($urandom()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_layer_sequencer.md
# lif_layer_sequencer

Time-multiplexing controller for a layer of `N` leaky integrate-and-fire neuron instances that share one set of configuration values. It accepts one timestep of input currents over a valid/ready handshake and latches them. It then pulses each neuron's `enable` once, in index order, and collects the resulting spikes into a vector. The vector is returned over a second valid/ready handshake. The block sits between the spike/current router upstream and the spike encoder downstream, and it owns the layer's threshold, decay and refractory registers.

## Interface
- `N`, default 8: number of neurons sequenced; range 2..16.
- `W`, default 5: width of current and threshold words; fixed at 5 for the current neuron.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset. The same net drives the neurons' reset.
- `step_valid` in 1: a timestep's currents are presented.
- `step_ready` out 1: block can accept a timestep.
- `step_current` in N*W: neuron i's current on bits [i*W +: W], two's complement.
- `neuron_current` out N*W: latched currents, wired to each neuron's `input_current`.
- `neuron_enable` out N: one-hot update strobe, at most one bit high per cycle.
- `threshold` out 5: layer threshold, to all neurons.
- `decay` out 3: layer decay code, to all neurons.
- `refractory_period` out 5: layer refractory period, to all neurons.
- `spike_in` in N: each neuron's `spike_out`.
- `spike_valid` out 1: spike vector available.
- `spike_ready` in 1: downstream accepts the spike vector.
- `spike_vec` out N: spikes of the completed timestep.
- `step_count` out 16: number of completed timesteps; wraps from 0xFFFF to 0.
- `cfg_we` in 1: configuration write strobe.
- `cfg_addr` in 2: 0 = threshold, 1 = decay, 2 = refractory_period, 3 = reserved.
- `cfg_wdata` in 5: write data; decay takes bits [2:0].
- `cfg_err` out 1: one-cycle pulse when a write is rejected.

## Operation
- The FSM has four states: IDLE, UPDATE, DRAIN, OUTPUT.
- IDLE:
  - `step_ready`=1.
  - On `step_valid`: latch `step_current` into `neuron_current`, clear `spike_vec`, set index=0, go to UPDATE.
- UPDATE:
  - `neuron_enable`=1<<index.
  - index increments every cycle.
  - After the cycle with index=N-1, go to DRAIN.
- DRAIN: one cycle with no enable, then go to OUTPUT.
- Spike capture:
  - A register `en_d` holds the previous cycle's `neuron_enable`.
  - In UPDATE and DRAIN, `spike_vec <= spike_vec | (spike_in & en_d)`.
  - Spikes outside the en_d mask are ignored.
- OUTPUT:
  - `spike_valid`=1 and `spike_vec` held stable.
  - On `spike_ready`: increment `step_count` and go to IDLE.
- `neuron_current` holds its value from latch until the next accepted step.
- Config writes:
  - Accepted only in IDLE, addr 0..2; the register updates on that edge.
  - A write in any other state, or to addr 3, is dropped and `cfg_err` pulses the next cycle.
  - Decay codes 5..7 are stored as written; the neuron treats them as zero leak.
- Simultaneous `cfg_we` and `step_valid` in IDLE: both take effect on the same edge. The new config applies to that step, since the first enable comes one cycle later.
- Reset values:
  - state IDLE, `neuron_enable`=0, `spike_vec`=0, `spike_valid`=0, `neuron_current`=0, `step_count`=0, `cfg_err`=0.
  - `threshold`=8, `decay`=1, `refractory_period`=2.
- Reset mid-step aborts the step with no output and restores all config defaults.

## Timing
- Step accepted at edge t means `neuron_enable[i]` is high in the cycle after edge t+i, for i=0..N-1.
- A spike from neuron i is visible on `spike_in[i]` in the cycle after its enable cycle. It is captured at edge t+i+2.
- `spike_valid` rises after edge t+N+1, with no downstream stall. `step_ready` is low from edge t until OUTPUT completes.
- Minimum step period is N+3 cycles when `spike_ready` is tied high.
- `spike_ready` asserted in a non-OUTPUT state has no effect.
- `step_valid` outside IDLE is not accepted; upstream holds its data.
- `step_count` increments on the OUTPUT handshake edge.

## Test plan
- **Reset defaults:** after reset deassert, require `threshold`=8, `decay`=1, `refractory_period`=2, `step_ready`=1, outputs 0.
- **Sequencing, N=8:** `step_valid` with `step_current` all 5'd3 and `spike_in` tied 0 -> enables walk 0x01..0x80 over 8 consecutive cycles, `spike_valid` after edge t+9, `spike_vec`=0, `step_count`=1 after ready.
- **Spike capture:** real neurons with threshold=4, currents {7,0,0,0,0,0,0,7} -> `spike_vec`=0x81 on the second step. Also drive a stray `spike_in[3]` pulse while enable[5] is active -> ignored.
- **Config rules:** write addr0=10 in IDLE, then write addr1 during UPDATE and write addr3 in IDLE -> `threshold`=10, `decay` unchanged, two `cfg_err` pulses.
- **Backpressure:** hold `spike_ready`=0 for 20 cycles -> `spike_vec` stable, `step_ready`=0, new `step_valid` not accepted. Release -> one `step_count` increment.
- **Reset mid-UPDATE:** at index 4 -> enables 0, no `spike_valid`, `step_count` unchanged, state IDLE.
